rf_writeback_ctrl: RTL and testbench

- Write-side controller for the integer register file; owns the RF write port (WE/WA/WD) that the register file samples on posedge CLK.
- Merges single-cycle ALU results with variable-latency load responses through a small load queue, then drives one write per cycle.
- Keeps a per-register pending scoreboard, so the issue stage stalls on RAW/WAW hazards against in-flight writes.

---
 rtl/rf_writeback_ctrl.sv | 154 +++++++++++++++
 tb/tb_rf_writeback_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_writeback_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rf_writeback_ctrl
// Brief    : Register-file write-port controller. It merges ALU results with
//            queued load responses and keeps a per-register pending scoreboard.
// Revision : 1.0
// ============================================================================

module rf_writeback_ctrl #(
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 5,
    parameter int MDEPTH   = 32,
    parameter int LQ_DEPTH = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ISS_VALID,
    input  logic [AWIDTH-1:0] ISS_RS1,
    input  logic [AWIDTH-1:0] ISS_RS2,
    input  logic [AWIDTH-1:0] ISS_RD,
    output logic              ISS_STALL,
    input  logic              ALU_VALID,
    input  logic [AWIDTH-1:0] ALU_RD,
    input  logic [DWIDTH-1:0] ALU_WD,
    input  logic              LD_VALID,
    output logic              LD_READY,
    input  logic [AWIDTH-1:0] LD_RD,
    input  logic [DWIDTH-1:0] LD_WD,
    output logic              WE,
    output logic [AWIDTH-1:0] WA,
    output logic [DWIDTH-1:0] WD,
    output logic [MDEPTH-1:0] PEND,
    output logic              WB_ERR
);

    localparam int                c_PTR_W   = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam logic [c_PTR_W:0]  c_PTR_ONE = {{c_PTR_W{1'b0}}, 1'b1};

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [c_PTR_W:0]    r_wptr;
    logic [c_PTR_W:0]    r_rptr;
    logic [AWIDTH-1:0]   r_lq_rd [LQ_DEPTH];
    logic [DWIDTH-1:0]   r_lq_wd [LQ_DEPTH];

    logic                r_we;
    logic [AWIDTH-1:0]   r_wa;
    logic [DWIDTH-1:0]   r_wd;
    logic [MDEPTH-1:0]   r_pend;
    logic                r_wb_err;

    logic                w_empty;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic                w_fire;
    logic                w_hazard;
    logic                w_sel_valid;
    logic [AWIDTH-1:0]   w_sel_rd;
    logic [DWIDTH-1:0]   w_sel_wd;
    logic [MDEPTH-1:0]   w_pend_nxt;
    logic [c_PTR_W-1:0]  w_widx;
    logic [c_PTR_W-1:0]  w_ridx;

    assign w_widx  = r_wptr[c_PTR_W-1:0];
    assign w_ridx  = r_rptr[c_PTR_W-1:0];
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[c_PTR_W] != r_rptr[c_PTR_W]) && (w_widx == w_ridx);

    // A pop in the same cycle is deliberately not credited to LD_READY.
    assign LD_READY = !w_full;
    assign w_push   = LD_VALID && !w_full;
    assign w_pop    = !ALU_VALID && !w_empty;

    assign w_hazard  = r_pend[ISS_RS1] | r_pend[ISS_RS2] | r_pend[ISS_RD];
    assign ISS_STALL = ISS_VALID && w_hazard;
    assign w_fire    = ISS_VALID && !w_hazard;

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_rd    = '0;
        w_sel_wd    = '0;
        if (ALU_VALID) begin
            w_sel_valid = 1'b1;
            w_sel_rd    = ALU_RD;
            w_sel_wd    = ALU_WD;
        end else if (!w_empty) begin
            w_sel_valid = 1'b1;
            w_sel_rd    = r_lq_rd[w_ridx];
            w_sel_wd    = r_lq_wd[w_ridx];
        end
    end

    // Clear is applied before set; the stall rule keeps them on distinct bits.
    always_comb begin
        w_pend_nxt = r_pend;
        if (r_we) begin
            w_pend_nxt[r_wa] = 1'b0;
        end
        if (w_fire && (ISS_RD != '0)) begin
            w_pend_nxt[ISS_RD] = 1'b1;
        end
        w_pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_lq_rd[w_widx] <= LD_RD;
            r_lq_wd[w_widx] <= LD_WD;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_we     <= 1'b0;
            r_wa     <= '0;
            r_wd     <= '0;
            r_pend   <= '0;
            r_wb_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end

            // Writes to x0 are consumed without touching the port.
            if (w_sel_valid && (w_sel_rd != '0)) begin
                r_we <= 1'b1;
                r_wa <= w_sel_rd;
                r_wd <= w_sel_wd;
            end else begin
                r_we <= 1'b0;
            end

            r_pend <= w_pend_nxt;

            if (r_we && !r_pend[r_wa]) begin
                r_wb_err <= 1'b1;
            end
        end
    end

    assign WE     = r_we;
    assign WA     = r_wa;
    assign WD     = r_wd;
    assign PEND   = r_pend;
    assign WB_ERR = r_wb_err;

endmodule

`default_nettype wire

// File: tb/tb_rf_writeback_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_writeback_ctrl
// Brief    : Directed self-checking bench for rf_writeback_ctrl.
// Revision : 1.0
// ============================================================================

module tb_rf_writeback_ctrl;

    localparam int DWIDTH   = 32;
    localparam int AWIDTH   = 5;
    localparam int MDEPTH   = 32;
    localparam int LQ_DEPTH = 2;

    logic              CLK = 1'b0;
    logic              RST;
    logic              ISS_VALID;
    logic [AWIDTH-1:0] ISS_RS1, ISS_RS2, ISS_RD;
    logic              ISS_STALL;
    logic              ALU_VALID;
    logic [AWIDTH-1:0] ALU_RD;
    logic [DWIDTH-1:0] ALU_WD;
    logic              LD_VALID;
    logic              LD_READY;
    logic [AWIDTH-1:0] LD_RD;
    logic [DWIDTH-1:0] LD_WD;
    logic              WE;
    logic [AWIDTH-1:0] WA;
    logic [DWIDTH-1:0] WD;
    logic [MDEPTH-1:0] PEND;
    logic              WB_ERR;

    int checks = 0;
    int errors = 0;

    rf_writeback_ctrl #(
        .DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .MDEPTH(MDEPTH), .LQ_DEPTH(LQ_DEPTH)
    ) dut (
        .CLK(CLK), .RST(RST),
        .ISS_VALID(ISS_VALID), .ISS_RS1(ISS_RS1), .ISS_RS2(ISS_RS2), .ISS_RD(ISS_RD),
        .ISS_STALL(ISS_STALL),
        .ALU_VALID(ALU_VALID), .ALU_RD(ALU_RD), .ALU_WD(ALU_WD),
        .LD_VALID(LD_VALID), .LD_READY(LD_READY), .LD_RD(LD_RD), .LD_WD(LD_WD),
        .WE(WE), .WA(WA), .WD(WD), .PEND(PEND), .WB_ERR(WB_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // A fire that sets a bit while the same bit is being cleared must never happen.
    always @(posedge CLK) begin
        if (!RST && ISS_VALID && !ISS_STALL && (ISS_RD != '0) && WE && (WA == ISS_RD)) begin
            errors++;
            $error("FAIL set_clear_same_bit: rd=%0d wa=%0d", ISS_RD, WA);
        end
    end

    initial begin
        RST = 1'b1; ISS_VALID = 1'b0; ISS_RS1 = '0; ISS_RS2 = '0; ISS_RD = '0;
        ALU_VALID = 1'b0; ALU_RD = '0; ALU_WD = '0;
        LD_VALID = 1'b0; LD_RD = '0; LD_WD = '0;
        tick(); tick();
        chk("rst_we",     64'(WE), 64'd0);
        chk("rst_wa",     64'(WA), 64'd0);
        chk("rst_wd",     64'(WD), 64'd0);
        chk("rst_pend",   64'(PEND), 64'd0);
        chk("rst_wberr",  64'(WB_ERR), 64'd0);
        chk("rst_ldrdy",  64'(LD_READY), 64'd1);
        RST = 1'b0;

        // ---- ALU basic ----
        ISS_VALID = 1'b1; ISS_RS1 = 5'd1; ISS_RS2 = 5'd2; ISS_RD = 5'd5;
        #1 chk("alu_iss_nostall", 64'(ISS_STALL), 64'd0);
        tick();
        chk("alu_pend5_set", 64'(PEND), 64'h20);
        ISS_VALID = 1'b0;
        ALU_VALID = 1'b1; ALU_RD = 5'd5; ALU_WD = 32'h1234;
        tick();
        chk("alu_we",  64'(WE), 64'd1);
        chk("alu_wa",  64'(WA), 64'd5);
        chk("alu_wd",  64'(WD), 64'h1234);
        chk("alu_pend_still", 64'(PEND), 64'h20);
        ALU_VALID = 1'b0;
        ISS_VALID = 1'b1; ISS_RS1 = 5'd5; ISS_RS2 = 5'd0; ISS_RD = 5'd6;
        #1 chk("alu_raw_stall", 64'(ISS_STALL), 64'd1);
        tick();
        chk("alu_pend_clr", 64'(PEND), 64'd0);
        chk("alu_we_off",   64'(WE), 64'd0);
        chk("alu_raw_fire", 64'(ISS_STALL), 64'd0);
        tick();
        chk("alu_pend6_set", 64'(PEND), 64'h40);
        ISS_VALID = 1'b0;
        ALU_VALID = 1'b1; ALU_RD = 5'd6; ALU_WD = 32'hAAAA;
        tick();
        chk("alu6_wa", 64'(WA), 64'd6);
        ALU_VALID = 1'b0;
        tick();
        chk("alu6_pend_clr", 64'(PEND), 64'd0);
        chk("alu6_wberr",    64'(WB_ERR), 64'd0);

        // ---- Load vs ALU conflict ----
        ISS_VALID = 1'b1; ISS_RS1 = '0; ISS_RS2 = '0; ISS_RD = 5'd3;
        tick();
        ISS_RD = 5'd4;
        tick();
        ISS_VALID = 1'b0;
        chk("cf_pend", 64'(PEND), 64'h18);
        LD_VALID = 1'b1; LD_RD = 5'd3; LD_WD = 32'hBEEF;
        ALU_VALID = 1'b1; ALU_RD = 5'd4; ALU_WD = 32'h4444;
        tick();
        LD_VALID = 1'b0; ALU_VALID = 1'b0;
        chk("cf_first_wa", 64'(WA), 64'd4);
        chk("cf_first_wd", 64'(WD), 64'h4444);
        tick();
        chk("cf_second_we", 64'(WE), 64'd1);
        chk("cf_second_wa", 64'(WA), 64'd3);
        chk("cf_second_wd", 64'(WD), 64'hBEEF);
        chk("cf_pend_mid",  64'(PEND), 64'h08);
        tick();
        chk("cf_we_off",  64'(WE), 64'd0);
        chk("cf_pend_end", 64'(PEND), 64'd0);
        chk("cf_wberr",   64'(WB_ERR), 64'd0);

        // ---- Queue full, ALU starves loads with x0 results ----
        ISS_VALID = 1'b1; ISS_RD = 5'd10;
        tick();
        ISS_RD = 5'd11;
        tick();
        ISS_RD = 5'd12;
        tick();
        ISS_VALID = 1'b0;
        chk("qf_pend", 64'(PEND), 64'h1C00);
        ALU_VALID = 1'b1; ALU_RD = 5'd0; ALU_WD = 32'hDEAD;
        LD_VALID = 1'b1; LD_RD = 5'd10; LD_WD = 32'h1010;
        chk("qf_rdy0", 64'(LD_READY), 64'd1);
        tick();
        chk("qf_rdy1", 64'(LD_READY), 64'd1);
        LD_RD = 5'd11; LD_WD = 32'h1111;
        tick();
        chk("qf_full_rdy", 64'(LD_READY), 64'd0);
        chk("qf_x0_we",    64'(WE), 64'd0);
        LD_RD = 5'd12; LD_WD = 32'h1212;
        tick();
        chk("qf_still_full", 64'(LD_READY), 64'd0);
        chk("qf_starve_we",  64'(WE), 64'd0);
        ALU_VALID = 1'b0;
        tick();
        chk("qf_pop1_we", 64'(WE), 64'd1);
        chk("qf_pop1_wa", 64'(WA), 64'd10);
        chk("qf_pop1_wd", 64'(WD), 64'h1010);
        chk("qf_pop1_rdy", 64'(LD_READY), 64'd1);
        tick();
        LD_VALID = 1'b0;
        chk("qf_pop2_wa", 64'(WA), 64'd11);
        chk("qf_pop2_wd", 64'(WD), 64'h1111);
        chk("qf_pop2_pend", 64'(PEND), 64'h1800);
        tick();
        chk("qf_pop3_we", 64'(WE), 64'd1);
        chk("qf_pop3_wa", 64'(WA), 64'd12);
        chk("qf_pop3_wd", 64'(WD), 64'h1212);
        chk("qf_pop3_pend", 64'(PEND), 64'h1000);
        tick();
        chk("qf_end_we",   64'(WE), 64'd0);
        chk("qf_end_pend", 64'(PEND), 64'd0);
        chk("qf_wberr",    64'(WB_ERR), 64'd0);

        // ---- x0 handling ----
        ISS_VALID = 1'b1; ISS_RS1 = '0; ISS_RS2 = '0; ISS_RD = '0;
        #1 chk("x0_nostall", 64'(ISS_STALL), 64'd0);
        ALU_VALID = 1'b1; ALU_RD = '0; ALU_WD = 32'hFFFF;
        tick();
        ISS_VALID = 1'b0; ALU_VALID = 1'b0;
        chk("x0_pend", 64'(PEND), 64'd0);
        chk("x0_alu_we", 64'(WE), 64'd0);
        LD_VALID = 1'b1; LD_RD = '0; LD_WD = 32'h5555;
        tick();
        LD_VALID = 1'b0;
        tick();
        chk("x0_ld_we", 64'(WE), 64'd0);
        tick();
        chk("x0_ld_we2",  64'(WE), 64'd0);
        chk("x0_wberr",   64'(WB_ERR), 64'd0);
        chk("x0_rdy",     64'(LD_READY), 64'd1);
        chk("x0_wa_hold", 64'(WA), 64'd12);

        // ---- Error flag ----
        ALU_VALID = 1'b1; ALU_RD = 5'd7; ALU_WD = 32'h7777;
        tick();
        ALU_VALID = 1'b0;
        chk("err_we", 64'(WE), 64'd1);
        chk("err_wa", 64'(WA), 64'd7);
        chk("err_not_yet", 64'(WB_ERR), 64'd0);
        tick();
        chk("err_set", 64'(WB_ERR), 64'd1);
        tick(); tick();
        chk("err_sticky", 64'(WB_ERR), 64'd1);

        // ---- Reset mid-operation ----
        ISS_VALID = 1'b1; ISS_RD = 5'd3;
        tick();
        ISS_RD = 5'd9;
        tick();
        ISS_VALID = 1'b0;
        ALU_VALID = 1'b1; ALU_RD = '0;
        LD_VALID = 1'b1; LD_RD = 5'd3; LD_WD = 32'h3333;
        tick();
        LD_RD = 5'd9; LD_WD = 32'h9999;
        tick();
        chk("rm_full", 64'(LD_READY), 64'd0);
        chk("rm_pend", 64'(PEND), 64'h208);
        RST = 1'b1; ALU_VALID = 1'b1; ALU_RD = 5'd2; ALU_WD = 32'h2222;
        LD_RD = 5'd1; LD_WD = 32'h1111;
        tick();
        RST = 1'b0; ALU_VALID = 1'b0; LD_VALID = 1'b0;
        chk("rm_we",    64'(WE), 64'd0);
        chk("rm_pend0", 64'(PEND), 64'd0);
        chk("rm_rdy",   64'(LD_READY), 64'd1);
        chk("rm_wberr", 64'(WB_ERR), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rm_no_write", 64'(WE), 64'd0);
        end
        chk("rm_wa_zero", 64'(WA), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
